// File: rtl/l15_anycoredecoder.sv
// AnyCore -> L1.5 request decoder: captures I$ fill, D$ load and D$ store requests and issues them
// one at a time over val/ack. Optional NC window build macro: L15_ANYCORE_NC_WINDOW_EN.
module l15_anycoredecoder #(
    parameter int                 PADDR_W     = 40,
    parameter int                 IC_LINE_LSB = 5,
    parameter int                 DC_LINE_LSB = 4,
    parameter logic [PADDR_W-1:0] NC_BASE     = 40'hF0_0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               anycore_ic2mem_reqvalid,
    input  logic [PADDR_W-1:0] anycore_ic2mem_reqaddr,
    input  logic               anycore_dc2mem_ldvalid,
    input  logic [PADDR_W-1:0] anycore_dc2mem_ldaddr,
    input  logic               anycore_dc2mem_stvalid,
    input  logic [PADDR_W-1:0] anycore_dc2mem_staddr,
    input  logic [63:0]        anycore_dc2mem_stdata,
    input  logic [1:0]         anycore_dc2mem_stsize,
    input  logic               anycore_mem2ic_respvalid,
    input  logic               anycore_mem2dc_ldvalid,
    input  logic               anycore_mem2dc_stcomplete,
    output logic               transducer_l15_val,
    output logic [4:0]         transducer_l15_rqtype,
    output logic [PADDR_W-1:0] transducer_l15_address,
    output logic [2:0]         transducer_l15_size,
    output logic [63:0]        transducer_l15_data,
    output logic               transducer_l15_nc,
    input  logic               l15_transducer_ack,
    output logic               decoder_busy
);

    localparam logic [4:0] LOAD_RQ  = 5'b00000;
    localparam logic [4:0] IMISS_RQ = 5'b10000;
    localparam logic [4:0] STORE_RQ = 5'b00001;

    localparam logic [1:0] CL_IFILL = 2'd0;
    localparam logic [1:0] CL_LOAD  = 2'd1;
    localparam logic [1:0] CL_STORE = 2'd2;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_REQ = 1'b1} state_t;

    function automatic logic [1:0] next_cls(input logic [1:0] c);
        logic [1:0] n;
        case (c)
            CL_IFILL: n = CL_LOAD;
            CL_LOAD:  n = CL_STORE;
            default:  n = CL_IFILL;
        endcase
        return n;
    endfunction

    // L1.5 wants store data big-endian: byte 0 lands in [63:56]
    function automatic logic [63:0] byte_swap64(input logic [63:0] d);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) begin
            r[8*(7-i) +: 8] = d[8*i +: 8];
        end
        return r;
    endfunction

    state_t             r_state;
    logic [2:0]         r_pending;
    logic [2:0]         r_outstanding;
    logic [1:0]         r_rr_ptr;
    logic [1:0]         r_cur;
    logic [PADDR_W-1:0] r_ic_addr;
    logic [PADDR_W-1:0] r_ld_addr;
    logic [PADDR_W-1:0] r_st_addr;
    logic [63:0]        r_st_data;
    logic [1:0]         r_st_size;
    logic               r_val;
    logic [4:0]         r_rqtype;
    logic [PADDR_W-1:0] r_address;
    logic [2:0]         r_size;
    logic [63:0]        r_data;
    logic               r_nc;

    logic [2:0]         w_strobe;
    logic [2:0]         w_retire;
    logic [2:0]         w_accept;
    logic [2:0]         w_ack_clr;
    logic [1:0]         w_c0;
    logic [1:0]         w_c1;
    logic [1:0]         w_c2;
    logic               w_sel_valid;
    logic [1:0]         w_sel;
    logic [4:0]         w_rqtype;
    logic [PADDR_W-1:0] w_address;
    logic [2:0]         w_size;
    logic [63:0]        w_data;
    logic               w_nc;
    logic               w_unused;

    assign w_strobe  = {anycore_dc2mem_stvalid, anycore_dc2mem_ldvalid, anycore_ic2mem_reqvalid};
    assign w_retire  = {anycore_mem2dc_stcomplete, anycore_mem2dc_ldvalid, anycore_mem2ic_respvalid};
    // A retire in the same cycle frees the class, so a simultaneous new strobe is accepted
    assign w_accept  = w_strobe & ~r_pending & ~(r_outstanding & ~w_retire);
    assign w_ack_clr = ((r_state == ST_REQ) && l15_transducer_ack) ? (3'b001 << r_cur) : 3'b000;

    assign w_c0 = r_rr_ptr;
    assign w_c1 = next_cls(w_c0);
    assign w_c2 = next_cls(w_c1);

    assign w_unused = &{1'b0, r_ic_addr[IC_LINE_LSB-1:0], r_ld_addr[DC_LINE_LSB-1:0], NC_BASE};

    // Round-robin pick among pending classes and build the request fields for it
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel       = w_c0;
        w_rqtype    = 5'b00000;
        w_address   = {PADDR_W{1'b0}};
        w_size      = 3'b000;
        w_data      = 64'd0;
        w_nc        = 1'b0;
        if (r_pending[w_c0]) begin
            w_sel_valid = 1'b1;
            w_sel       = w_c0;
        end else if (r_pending[w_c1]) begin
            w_sel_valid = 1'b1;
            w_sel       = w_c1;
        end else if (r_pending[w_c2]) begin
            w_sel_valid = 1'b1;
            w_sel       = w_c2;
        end else begin
            w_sel_valid = 1'b0;
            w_sel       = w_c0;
        end
        case (w_sel)
            CL_IFILL: begin
                w_rqtype  = IMISS_RQ;
                w_address = {r_ic_addr[PADDR_W-1:IC_LINE_LSB], {IC_LINE_LSB{1'b0}}};
                w_size    = 3'b111;
            end
            CL_LOAD: begin
                w_rqtype  = LOAD_RQ;
                w_address = {r_ld_addr[PADDR_W-1:DC_LINE_LSB], {DC_LINE_LSB{1'b0}}};
                w_size    = 3'b110;
`ifdef L15_ANYCORE_NC_WINDOW_EN
                if (r_ld_addr >= NC_BASE) begin
                    w_nc      = 1'b1;
                    w_size    = 3'b100;
                    w_address = {r_ld_addr[PADDR_W-1:3], 3'b000};
                end else begin
                    w_nc      = 1'b0;
                end
`endif
            end
            CL_STORE: begin
                w_rqtype  = STORE_RQ;
                w_address = r_st_addr;
                w_size    = {1'b0, r_st_size} + 3'd1;
                w_data    = byte_swap64(r_st_data);
`ifdef L15_ANYCORE_NC_WINDOW_EN
                w_nc      = (r_st_addr >= NC_BASE);
`endif
            end
            default: begin
                w_rqtype  = 5'b00000;
                w_address = {PADDR_W{1'b0}};
            end
        endcase
    end

    // Capture, class bookkeeping and the IDLE/REQ issue FSM with registered request outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_pending     <= 3'b000;
            r_outstanding <= 3'b000;
            r_rr_ptr      <= CL_IFILL;
            r_cur         <= CL_IFILL;
            r_ic_addr     <= {PADDR_W{1'b0}};
            r_ld_addr     <= {PADDR_W{1'b0}};
            r_st_addr     <= {PADDR_W{1'b0}};
            r_st_data     <= 64'd0;
            r_st_size     <= 2'd0;
            r_val         <= 1'b0;
            r_rqtype      <= 5'b00000;
            r_address     <= {PADDR_W{1'b0}};
            r_size        <= 3'b000;
            r_data        <= 64'd0;
            r_nc          <= 1'b0;
        end else begin
            r_pending     <= (r_pending & ~w_ack_clr) | w_accept;
            r_outstanding <= (r_outstanding & ~w_retire) | w_ack_clr;
            if (w_accept[0]) r_ic_addr <= anycore_ic2mem_reqaddr;
            if (w_accept[1]) r_ld_addr <= anycore_dc2mem_ldaddr;
            if (w_accept[2]) begin
                r_st_addr <= anycore_dc2mem_staddr;
                r_st_data <= anycore_dc2mem_stdata;
                r_st_size <= anycore_dc2mem_stsize;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_sel_valid) begin
                        r_state   <= ST_REQ;
                        r_val     <= 1'b1;
                        r_cur     <= w_sel;
                        r_rqtype  <= w_rqtype;
                        r_address <= w_address;
                        r_size    <= w_size;
                        r_data    <= w_data;
                        r_nc      <= w_nc;
                    end
                end
                ST_REQ: begin
                    if (l15_transducer_ack) begin
                        r_state  <= ST_IDLE;
                        r_val    <= 1'b0;
                        r_rr_ptr <= next_cls(r_cur);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_val   <= 1'b0;
                end
            endcase
        end
    end

    assign transducer_l15_val     = r_val;
    assign transducer_l15_rqtype  = r_rqtype;
    assign transducer_l15_address = r_address;
    assign transducer_l15_size    = r_size;
    assign transducer_l15_data    = r_data;
    assign transducer_l15_nc      = r_nc;
    assign decoder_busy           = (|r_pending) | (|r_outstanding) | r_val;

endmodule

// File: tb/tb_l15_anycoredecoder.sv
// Directed self-checking bench for l15_anycoredecoder (drive and sample on the falling clock edge).
module tb_l15_anycoredecoder;

    localparam logic [4:0] E_LOAD  = 5'b00000;
    localparam logic [4:0] E_IMISS = 5'b10000;
    localparam logic [4:0] E_STORE = 5'b00001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ic_valid = 1'b0;
    logic [39:0] ic_addr = 40'd0;
    logic        ld_valid = 1'b0;
    logic [39:0] ld_addr = 40'd0;
    logic        st_valid = 1'b0;
    logic [39:0] st_addr = 40'd0;
    logic [63:0] st_data = 64'd0;
    logic [1:0]  st_size = 2'd0;
    logic        ic_resp = 1'b0;
    logic        ld_resp = 1'b0;
    logic        st_resp = 1'b0;
    logic        ack = 1'b0;
    logic        val;
    logic [4:0]  rqtype;
    logic [39:0] address;
    logic [2:0]  size;
    logic [63:0] data;
    logic        nc;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    l15_anycoredecoder dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .anycore_ic2mem_reqvalid   (ic_valid),
        .anycore_ic2mem_reqaddr    (ic_addr),
        .anycore_dc2mem_ldvalid    (ld_valid),
        .anycore_dc2mem_ldaddr     (ld_addr),
        .anycore_dc2mem_stvalid    (st_valid),
        .anycore_dc2mem_staddr     (st_addr),
        .anycore_dc2mem_stdata     (st_data),
        .anycore_dc2mem_stsize     (st_size),
        .anycore_mem2ic_respvalid  (ic_resp),
        .anycore_mem2dc_ldvalid    (ld_resp),
        .anycore_mem2dc_stcomplete (st_resp),
        .transducer_l15_val        (val),
        .transducer_l15_rqtype     (rqtype),
        .transducer_l15_address    (address),
        .transducer_l15_size       (size),
        .transducer_l15_data       (data),
        .transducer_l15_nc         (nc),
        .l15_transducer_ack        (ack),
        .decoder_busy              (busy)
    );

    task automatic wait_val(input string name);
        int n;
        n = 0;
        while (val !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (val !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: val=%b required 1", name, val);
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({val, rqtype, address, size, data, nc, busy} !== 116'd0) begin
            errors++;
            $display("FAIL reset_outputs: val=%b rq=%h addr=%h size=%h data=%h nc=%b busy=%b required all 0",
                     val, rqtype, address, size, data, nc, busy);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_ifill();
        ic_valid = 1'b1;
        ic_addr  = 40'h00_1234_567F;
        @(negedge clk);
        ic_valid = 1'b0;
        checks++;
        if (val !== 1'b0) begin errors++; $display("FAIL ifill_latency1: val=%b required 0", val); end
        @(negedge clk);
        checks++;
        if (val !== 1'b1) begin errors++; $display("FAIL ifill_latency2: val=%b required 1", val); end
        checks++;
        if (address !== 40'h00_1234_5660) begin errors++; $display("FAIL ifill_addr: got %h required 0012345660", address); end
        checks++;
        if (size !== 3'b111 || rqtype !== E_IMISS || data !== 64'd0 || nc !== 1'b0) begin
            errors++;
            $display("FAIL ifill_fields: size=%b rq=%b data=%h nc=%b required 111 10000 0 0", size, rqtype, data, nc);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (val !== 1'b1 || address !== 40'h00_1234_5660) begin
            errors++;
            $display("FAIL ifill_hold: val=%b addr=%h required 1 0012345660", val, address);
        end
        do_ack();
        checks++;
        if (val !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL ifill_after_ack: val=%b busy=%b required 0 1", val, busy);
        end
        ic_resp = 1'b1;
        @(negedge clk);
        ic_resp = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL ifill_retire: busy=%b required 0", busy); end
    endtask

    task automatic test_store();
        st_valid = 1'b1;
        st_addr  = 40'h00_0000_0080;
        st_size  = 2'd3;
        st_data  = 64'h0102_0304_0506_0708;
        @(negedge clk);
        st_valid = 1'b0;
        wait_val("store8");
        checks++;
        if (data !== 64'h0807_0605_0403_0201 || size !== 3'b100 || rqtype !== E_STORE || address !== 40'h80) begin
            errors++;
            $display("FAIL store8_fields: data=%h size=%b rq=%b addr=%h required 0807060504030201 100 00001 80",
                     data, size, rqtype, address);
        end
        do_ack();
        st_resp = 1'b1;
        @(negedge clk);
        st_resp = 1'b0;
        st_valid = 1'b1;
        st_addr  = 40'h00_0000_0081;
        st_size  = 2'd0;
        st_data  = 64'h0000_0000_0000_00AB;
        @(negedge clk);
        st_valid = 1'b0;
        wait_val("store1");
        checks++;
        if (data !== 64'hAB00_0000_0000_0000 || size !== 3'b001 || address !== 40'h81) begin
            errors++;
            $display("FAIL store1_fields: data=%h size=%b addr=%h required ab00000000000000 001 81", data, size, address);
        end
        do_ack();
        st_resp = 1'b1;
        @(negedge clk);
        st_resp = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL store_retire: busy=%b required 0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [4:0]  exp_rq [3];
        logic [39:0] exp_ad [3];
        exp_rq[0] = E_IMISS; exp_ad[0] = 40'h00_0000_1000;
        exp_rq[1] = E_LOAD;  exp_ad[1] = 40'h00_0000_2000;
        exp_rq[2] = E_STORE; exp_ad[2] = 40'h00_0000_3004;
        ic_valid = 1'b1; ic_addr = 40'h00_0000_1010;
        ld_valid = 1'b1; ld_addr = 40'h00_0000_2008;
        st_valid = 1'b1; st_addr = 40'h00_0000_3004; st_size = 2'd2; st_data = 64'h0;
        @(negedge clk);
        ic_valid = 1'b0; ld_valid = 1'b0; st_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            wait_val("b2b");
            checks++;
            if (rqtype !== exp_rq[k] || address !== exp_ad[k]) begin
                errors++;
                $display("FAIL b2b_order%0d: rq=%b addr=%h required %b %h", k, rqtype, address, exp_rq[k], exp_ad[k]);
            end
            do_ack();
            checks++;
            if (val !== 1'b0) begin errors++; $display("FAIL b2b_gap%0d: val=%b required 0", k, val); end
        end
        ic_resp = 1'b1; ld_resp = 1'b1; st_resp = 1'b1;
        @(negedge clk);
        ic_resp = 1'b0; ld_resp = 1'b0; st_resp = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_retire: busy=%b required 0", busy); end
    endtask

    task automatic test_dup_load();
        logic seen;
        ld_valid = 1'b1; ld_addr = 40'h00_0000_0100;
        @(negedge clk);
        ld_valid = 1'b0;
        wait_val("dup_first");
        do_ack();
        ld_valid = 1'b1; ld_addr = 40'h00_0000_0200;
        @(negedge clk);
        ld_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (val === 1'b1) seen = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (seen !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL dup_ignored: val_seen=%b busy=%b required 0 1", seen, busy);
        end
        ld_resp = 1'b1; ld_valid = 1'b1; ld_addr = 40'h00_0000_0345;
        @(negedge clk);
        ld_resp = 1'b0; ld_valid = 1'b0;
        wait_val("dup_reissue");
        checks++;
        if (rqtype !== E_LOAD || address !== 40'h00_0000_0340 || size !== 3'b110) begin
            errors++;
            $display("FAIL dup_reissue: rq=%b addr=%h size=%b required 00000 340 110", rqtype, address, size);
        end
        do_ack();
        ld_resp = 1'b1;
        @(negedge clk);
        ld_resp = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL dup_retire: busy=%b required 0", busy); end
    endtask

    task automatic test_nc_load();
        logic       e_nc;
        logic [2:0] e_size;
`ifdef L15_ANYCORE_NC_WINDOW_EN
        e_nc = 1'b1; e_size = 3'b100;
`else
        e_nc = 1'b0; e_size = 3'b110;
`endif
        ld_valid = 1'b1; ld_addr = 40'hF0_0000_0013;
        @(negedge clk);
        ld_valid = 1'b0;
        wait_val("nc_load");
        checks++;
        if (nc !== e_nc || size !== e_size || address !== 40'hF0_0000_0010) begin
            errors++;
            $display("FAIL nc_load: nc=%b size=%b addr=%h required %b %b f000000010", nc, size, address, e_nc, e_size);
        end
        do_ack();
        ld_resp = 1'b1;
        @(negedge clk);
        ld_resp = 1'b0;
    endtask

    task automatic test_reset_mid_req();
        logic seen;
        st_valid = 1'b1; st_addr = 40'h00_0000_0040; st_size = 2'd3; st_data = 64'h1122_3344_5566_7788;
        @(negedge clk);
        st_valid = 1'b0;
        wait_val("rst_req");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (val !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: val=%b busy=%b required 0 0", val, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (val === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_no_reissue: activity=%b required 0", seen); end
    endtask

    initial begin
        test_reset();
        test_ifill();
        test_store();
        test_back_to_back();
        test_dup_load();
        test_nc_load();
        test_reset_mid_req();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
